// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the SPARC pipeline hazard controller.
// Holds the state encoding, forwarding selects and the %g0 register number.
package sparc_pipe_pkg;

  typedef logic [4:0] reg_t;
  typedef logic [1:0] fwd_t;
  typedef logic [1:0] st_t;

  localparam st_t ST_RUN        = 2'd0;
  localparam st_t ST_LOAD_STALL = 2'd1;
  localparam st_t ST_MEM_WAIT   = 2'd2;
  localparam st_t ST_HALT_RST   = 2'd3;

  localparam fwd_t FWD_RF  = 2'b00;
  localparam fwd_t FWD_EX  = 2'b01;
  localparam fwd_t FWD_MEM = 2'b10;
  localparam fwd_t FWD_WB  = 2'b11;

  localparam reg_t REG_G0 = 5'd0;

  function automatic logic fwd_hit(
    input logic use_op,
    input reg_t rs,
    input reg_t rd,
    input logic le
  );
    return use_op & le & (rd == rs) & (rs != REG_G0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
// master = datapath, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  import sparc_pipe_pkg::*;

  reg_t ID_rs1;
  reg_t ID_rs2;
  reg_t ID_rd;
  logic ID_use_rs1;
  logic ID_use_rs2;
  logic ID_use_rd;
  reg_t EX_RD;
  reg_t MEM_RD;
  reg_t WB_RD;
  logic EX_RF_LE;
  logic MEM_RF_LE;
  logic WB_RF_LE;
  logic EX_load;
  logic annul_delay;
  logic mem_busy;

  logic pc_le;
  logic if_id_le;
  logic if_id_clr;
  logic id_ex_clr;
  logic pipe_le;
  fwd_t fwd_sel1;
  fwd_t fwd_sel2;
  fwd_t fwd_sel3;

  modport master (
    output ID_rs1, ID_rs2, ID_rd,
    output ID_use_rs1, ID_use_rs2, ID_use_rd,
    output EX_RD, MEM_RD, WB_RD,
    output EX_RF_LE, MEM_RF_LE, WB_RF_LE,
    output EX_load, annul_delay, mem_busy,
    input  pc_le, if_id_le, if_id_clr,
    input  id_ex_clr, pipe_le,
    input  fwd_sel1, fwd_sel2, fwd_sel3
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rd,
    input  ID_use_rs1, ID_use_rs2, ID_use_rd,
    input  EX_RD, MEM_RD, WB_RD,
    input  EX_RF_LE, MEM_RF_LE, WB_RF_LE,
    input  EX_load, annul_delay, mem_busy,
    output pc_le, if_id_le, if_id_clr,
    output id_ex_clr, pipe_le,
    output fwd_sel1, fwd_sel2, fwd_sel3
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one ID-stage operand mux.
// Youngest producer wins: EX over MEM over WB, else register file.
module fwd_select
  import sparc_pipe_pkg::*;
(
  input  reg_t rs,
  input  logic use_op,
  input  reg_t ex_rd,
  input  logic ex_le,
  input  reg_t mem_rd,
  input  logic mem_le,
  input  reg_t wb_rd,
  input  logic wb_le,
  output fwd_t sel
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign hit_ex  = fwd_hit(use_op, rs, ex_rd, ex_le);
  assign hit_mem = fwd_hit(use_op, rs, mem_rd, mem_le);
  assign hit_wb  = fwd_hit(use_op, rs, wb_rd, wb_le);

  always_comb begin
    sel = FWD_RF;
    if (hit_ex)
      sel = FWD_EX;
    else if (hit_mem)
      sel = FWD_MEM;
    else if (hit_wb)
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage SPARC pipeline.
// Load-use bubble, memory freeze, delay-slot annul and forwarding.
module pipeline_hazard_ctrl
  import sparc_pipe_pkg::*;
#(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);
  localparam logic [WC_W-1:0] WC_TRIP = WC_W'(WAIT_MAX - 1);

  st_t             state;
  st_t             state_nx;
  logic [WC_W-1:0] wait_cnt;

  fwd_t s1;
  fwd_t s2;
  fwd_t s3;

  logic halt;
  logic lu;
  logic lu_eff;
  logic sel_halt;
  logic sel_busy;
  logic sel_lu;
  logic sel_ann;
  logic pc_le;

  fwd_select u_mx1 (
    .rs     (hz.ID_rs1),
    .use_op (hz.ID_use_rs1),
    .ex_rd  (hz.EX_RD),
    .ex_le  (hz.EX_RF_LE),
    .mem_rd (hz.MEM_RD),
    .mem_le (hz.MEM_RF_LE),
    .wb_rd  (hz.WB_RD),
    .wb_le  (hz.WB_RF_LE),
    .sel    (s1)
  );

  fwd_select u_mx2 (
    .rs     (hz.ID_rs2),
    .use_op (hz.ID_use_rs2),
    .ex_rd  (hz.EX_RD),
    .ex_le  (hz.EX_RF_LE),
    .mem_rd (hz.MEM_RD),
    .mem_le (hz.MEM_RF_LE),
    .wb_rd  (hz.WB_RD),
    .wb_le  (hz.WB_RF_LE),
    .sel    (s2)
  );

  fwd_select u_mx3 (
    .rs     (hz.ID_rd),
    .use_op (hz.ID_use_rd),
    .ex_rd  (hz.EX_RD),
    .ex_le  (hz.EX_RF_LE),
    .mem_rd (hz.MEM_RD),
    .mem_le (hz.MEM_RF_LE),
    .wb_rd  (hz.WB_RD),
    .wb_le  (hz.WB_RF_LE),
    .sel    (s3)
  );

  assign halt = !reset || (state == ST_HALT_RST);

  assign lu = hz.EX_load & hz.EX_RF_LE &
              (hz.EX_RD != REG_G0) &
              ((hz.ID_use_rs1 & (hz.ID_rs1 == hz.EX_RD)) |
               (hz.ID_use_rs2 & (hz.ID_rs2 == hz.EX_RD)) |
               (hz.ID_use_rd  & (hz.ID_rd  == hz.EX_RD)));

  // The bubble occupies EX during LOAD_STALL, so no second stall.
  assign lu_eff = lu & (state != ST_LOAD_STALL);

  assign sel_halt = halt;
  assign sel_busy = !halt & hz.mem_busy;
  assign sel_lu   = !halt & !hz.mem_busy & lu_eff;
  assign sel_ann  = !halt & !hz.mem_busy & !lu_eff &
                    hz.annul_delay;

  always_comb begin
    pc_le        = 1'b1;
    hz.if_id_le  = 1'b1;
    hz.pipe_le   = 1'b1;
    hz.if_id_clr = 1'b0;
    hz.id_ex_clr = 1'b0;
    state_nx     = ST_RUN;
    unique case (1'b1)
      sel_halt: begin
        pc_le        = 1'b0;
        hz.if_id_le  = 1'b0;
        hz.pipe_le   = 1'b0;
        hz.if_id_clr = 1'b1;
        hz.id_ex_clr = 1'b1;
      end
      sel_busy: begin
        pc_le       = 1'b0;
        hz.if_id_le = 1'b0;
        hz.pipe_le  = 1'b0;
        state_nx    = ST_MEM_WAIT;
      end
      sel_lu: begin
        pc_le        = 1'b0;
        hz.if_id_le  = 1'b0;
        hz.id_ex_clr = 1'b1;
        state_nx     = ST_LOAD_STALL;
      end
      sel_ann: begin
        hz.if_id_clr = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    hz.pc_le    = pc_le;
    hz.fwd_sel1 = halt ? FWD_RF : s1;
    hz.fwd_sel2 = halt ? FWD_RF : s2;
    hz.fwd_sel3 = halt ? FWD_RF : s3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_HALT_RST;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (!hz.mem_busy)
        wait_cnt <= '0;
      else if (wait_cnt != WC_MAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (hz.mem_busy && (wait_cnt >= WC_TRIP))
        mem_timeout <= 1'b1;
      if (!pc_le && (state != ST_HALT_RST) &&
          (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Directed vectors push expectations; a negedge monitor pops and checks.
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_FRZ = 5'b00000;
  localparam logic [4:0] C_LU  = 5'b00011;
  localparam logic [4:0] C_ANN = 5'b11101;
  localparam logic [4:0] C_RST = 5'b00110;

  typedef struct {
    string       nm;
    logic [4:0]  ctl;
    logic [5:0]  fwd;
    logic        to;
    logic [15:0] st;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  exp_t q[$];
  int checks;
  int failures;
  logic [15:0] exp_stall;
  logic        exp_to;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .WAIT_MAX (64),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_in();
    hz.ID_rs1      = 5'd0;
    hz.ID_rs2      = 5'd0;
    hz.ID_rd       = 5'd0;
    hz.ID_use_rs1  = 1'b0;
    hz.ID_use_rs2  = 1'b0;
    hz.ID_use_rd   = 1'b0;
    hz.EX_RD       = 5'd0;
    hz.MEM_RD      = 5'd0;
    hz.WB_RD       = 5'd0;
    hz.EX_RF_LE    = 1'b0;
    hz.MEM_RF_LE   = 1'b0;
    hz.WB_RF_LE    = 1'b0;
    hz.EX_load     = 1'b0;
    hz.annul_delay = 1'b0;
    hz.mem_busy    = 1'b0;
  endtask

  task automatic chk(
    input string      nm,
    input logic [4:0] ctl,
    input logic [5:0] fwd,
    input logic       halt
  );
    exp_t e;
    e.nm  = nm;
    e.ctl = ctl;
    e.fwd = fwd;
    e.to  = exp_to;
    e.st  = exp_stall;
    q.push_back(e);
    if (!halt && !ctl[4])
      exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu7();
    hz.EX_load    = 1'b1;
    hz.EX_RD      = 5'd7;
    hz.EX_RF_LE   = 1'b1;
    hz.ID_rs2     = 5'd7;
    hz.ID_use_rs2 = 1'b1;
  endtask

  task automatic set_bubble7();
    clr_in();
    hz.ID_rs2     = 5'd7;
    hz.ID_use_rs2 = 1'b1;
    hz.MEM_RD     = 5'd7;
    hz.MEM_RF_LE  = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] a_ctl;
    logic [5:0] a_fwd;
    if (q.size() > 0) begin
      e = q.pop_front();
      a_ctl = {hz.pc_le, hz.if_id_le, hz.if_id_clr,
               hz.id_ex_clr, hz.pipe_le};
      a_fwd = {hz.fwd_sel1, hz.fwd_sel2, hz.fwd_sel3};
      checks++;
      if ({a_ctl, a_fwd, mem_timeout, stall_cycles} !==
          {e.ctl, e.fwd, e.to, e.st}) begin
        failures++;
        $display("FAIL %s: got ctl=%b fwd=%b to=%b st=%0d, want ctl=%b fwd=%b to=%b st=%0d",
                 e.nm, a_ctl, a_fwd, mem_timeout,
                 stall_cycles, e.ctl, e.fwd, e.to, e.st);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = 16'd0;
    exp_to    = 1'b0;
    reset     = 1'b0;
    clr_in();
    @(posedge clk);
    #1;
    chk("reset", C_RST, 6'b0, 1'b1);
    reset = 1'b1;
    chk("halt_rst", C_RST, 6'b0, 1'b1);
    chk("run_idle", C_RUN, 6'b0, 1'b0);

    hz.ID_rs1 = 5'd5; hz.ID_use_rs1 = 1'b1;
    hz.EX_RD = 5'd5;  hz.EX_RF_LE = 1'b1;
    hz.MEM_RD = 5'd5; hz.MEM_RF_LE = 1'b1;
    chk("fwd_ex_prio", C_RUN, 6'b01_00_00, 1'b0);
    hz.ID_rs1 = 5'd0; hz.EX_RD = 5'd0;
    hz.MEM_RD = 5'd0;
    chk("fwd_g0", C_RUN, 6'b0, 1'b0);
    hz.ID_rs1 = 5'd5; hz.EX_RD = 5'd5;
    hz.MEM_RD = 5'd5; hz.EX_RF_LE = 1'b0;
    chk("fwd_ex_noLE", C_RUN, 6'b10_00_00, 1'b0);
    hz.ID_use_rs1 = 1'b0;
    chk("fwd_unused", C_RUN, 6'b0, 1'b0);
    clr_in();
    hz.ID_rs2 = 5'd9; hz.ID_use_rs2 = 1'b1;
    hz.MEM_RD = 5'd9; hz.MEM_RF_LE = 1'b1;
    hz.ID_rd = 5'd3;  hz.ID_use_rd = 1'b1;
    hz.WB_RD = 5'd3;  hz.WB_RF_LE = 1'b1;
    chk("fwd_mem_wb", C_RUN, 6'b00_10_11, 1'b0);
    clr_in();
    hz.EX_load = 1'b1; hz.EX_RF_LE = 1'b1;
    hz.ID_use_rs1 = 1'b1;
    chk("lu_g0", C_RUN, 6'b0, 1'b0);

    clr_in(); set_lu7();
    chk("lu_stall", C_LU, 6'b00_01_00, 1'b0);
    set_bubble7();
    chk("lu_fwd_mem", C_RUN, 6'b00_10_00, 1'b0);
    clr_in();
    chk("lu_back_run", C_RUN, 6'b0, 1'b0);

    hz.annul_delay = 1'b1;
    chk("annul", C_ANN, 6'b0, 1'b0);
    clr_in();
    chk("annul_once", C_RUN, 6'b0, 1'b0);
    set_lu7(); hz.annul_delay = 1'b1;
    chk("annul_in_lu", C_LU, 6'b00_01_00, 1'b0);
    set_bubble7();
    chk("annul_lu_bub", C_RUN, 6'b00_10_00, 1'b0);

    clr_in(); hz.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      chk("mem_wait3", C_FRZ, 6'b0, 1'b0);
    clr_in();
    chk("mem_release", C_RUN, 6'b0, 1'b0);

    set_lu7(); hz.mem_busy = 1'b1;
    chk("busy_lu_frz", C_FRZ, 6'b00_01_00, 1'b0);
    hz.mem_busy = 1'b0;
    chk("busy_lu_rel", C_LU, 6'b00_01_00, 1'b0);
    set_bubble7();
    chk("busy_lu_bub", C_RUN, 6'b00_10_00, 1'b0);

    clr_in(); hz.mem_busy = 1'b1;
    for (int i = 0; i < 64; i++)
      chk("wdog_pre", C_FRZ, 6'b0, 1'b0);
    exp_to = 1'b1;
    chk("wdog_set", C_FRZ, 6'b0, 1'b0);
    hz.mem_busy = 1'b0;
    chk("wdog_sticky", C_RUN, 6'b0, 1'b0);
    chk("wdog_sticky2", C_RUN, 6'b0, 1'b0);

    hz.mem_busy = 1'b1;
    chk("pre_rst_wait", C_FRZ, 6'b0, 1'b0);
    reset = 1'b0;
    exp_stall = 16'd0;
    exp_to = 1'b0;
    chk("rst_mid_wait", C_RST, 6'b0, 1'b1);
    reset = 1'b1;
    hz.mem_busy = 1'b0;
    chk("rst_release", C_RST, 6'b0, 1'b1);
    chk("rst_run", C_RUN, 6'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
